// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared state encoding and register-address width for the hazard controller
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational load-use match of ID sources against EX destination
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] R1_addr_ID,
  input  logic [REG_ADDR_W-1:0] R2_addr_ID,
  input  logic                  uses_R1_ID,
  input  logic                  uses_R2_ID,
  input  logic [REG_ADDR_W-1:0] R3_addr_EX,
  input  logic                  load_EX,
  output logic                  lu
);

  logic r1_match;
  logic r2_match;

  assign r1_match = uses_R1_ID && (R1_addr_ID == R3_addr_EX);
  assign r2_match = uses_R2_ID && (R2_addr_ID == R3_addr_EX);

  // x0 is hardwired to zero, so a load targeting it never produces a dependency
  assign lu = load_EX && (R3_addr_EX != '0) && (r1_match || r2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline with memory watchdog and stall counter
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] R1_addr_ID,
  input  logic [REG_ADDR_W-1:0] R2_addr_ID,
  input  logic                  uses_R1_ID,
  input  logic                  uses_R2_ID,
  input  logic [REG_ADDR_W-1:0] R3_addr_EX,
  input  logic                  load_EX,
  input  logic                  mem_req_MM,
  input  logic                  mem_ready,
  input  logic                  branch_taken_EX,
  output logic                  pc_en,
  output logic                  IF_en,
  output logic                  ID_en,
  output logic                  EX_en,
  output logic                  MM_en,
  output logic                  flush_IF,
  output logic                  flush_ID,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_count
);

  state_t             state;
  state_t             state_next;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   timer_next;
  logic               timeout_next;
  logic               lu;
  logic               mw;
  logic               run_rules;

  hazard_detect u_hazard_detect (
    .R1_addr_ID (R1_addr_ID),
    .R2_addr_ID (R2_addr_ID),
    .uses_R1_ID (uses_R1_ID),
    .uses_R2_ID (uses_R2_ID),
    .R3_addr_EX (R3_addr_EX),
    .load_EX    (load_EX),
    .lu         (lu)
  );

  assign mw = mem_req_MM && !mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      timer       <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      mem_timeout <= timeout_next;
      if (!pc_en && (state != ERROR) && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next   = state;
    timer_next   = timer;
    timeout_next = mem_timeout;
    unique case (state)
      RUN: begin
        if (mw) begin
          state_next = MEM_WAIT;
          timer_next = TMR_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_next = RUN;
          timer_next = '0;
        end else if (timer == TMR_W'(MEM_TIMEOUT)) begin
          state_next   = ERROR;
          timeout_next = 1'b1;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      default: begin
        state_next = ERROR;
      end
    endcase
  end

  // The release cycle out of MEM_WAIT resolves branch/load-use exactly as RUN would
  always_comb begin
    pc_en     = 1'b0;
    IF_en     = 1'b0;
    ID_en     = 1'b0;
    EX_en     = 1'b0;
    MM_en     = 1'b0;
    flush_IF  = 1'b0;
    flush_ID  = 1'b0;
    run_rules = 1'b0;
    unique case (state)
      RUN:      run_rules = !mw;
      MEM_WAIT: run_rules = mem_ready;
      default:  run_rules = 1'b0;
    endcase
    if (reset && run_rules) begin
      ID_en = 1'b1;
      EX_en = 1'b1;
      MM_en = 1'b1;
      if (branch_taken_EX) begin
        pc_en    = 1'b1;
        IF_en    = 1'b1;
        flush_IF = 1'b1;
        flush_ID = 1'b1;
      end else if (lu) begin
        flush_ID = 1'b1;
      end else begin
        pc_en = 1'b1;
        IF_en = 1'b1;
      end
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the enable and synchronous-clear inputs of the PC and of the IF/ID, ID/EX, EX/MM and MM/WB pipeline registers, including the enable of the EX/MM register.
It resolves three events: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses in MM.
It adds a timeout watchdog on memory and a stall-cycle counter for performance debug.

Parameters:
MEM_TIMEOUT, 15, max cycles spent in MEM_WAIT before declaring an error (1..2^TMR_W-1)
TMR_W, 4, width of the memory wait timer
CNT_W, 16, width of stall_count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
R1_addr_ID  in  5  source register 1 of the instruction in ID
R2_addr_ID  in  5  source register 2 of the instruction in ID
uses_R1_ID  in  1  instruction in ID reads R1
uses_R2_ID  in  1  instruction in ID reads R2
R3_addr_EX  in  5  destination register of the instruction in EX
load_EX  in  1  instruction in EX is a load
mem_req_MM  in  1  instruction in MM accesses data memory
mem_ready  in  1  data memory completes access this cycle
branch_taken_EX  in  1  branch/jump in EX resolved taken
pc_en  out  1  PC update enable
IF_en  out  1  IF/ID register enable
ID_en  out  1  ID/EX register enable
EX_en  out  1  EX/MM register enable
MM_en  out  1  MM/WB register enable
flush_IF  out  1  synchronous clear of IF/ID (acts at next edge)
flush_ID  out  1  synchronous clear of ID/EX (acts at next edge)
mem_timeout  out  1  sticky error flag
stall_count  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- States: RUN, MEM_WAIT, ERROR. State, timer, stall_count and mem_timeout are registers. All other outputs are combinational from state and inputs.
- While reset=0: state=RUN, timer=0, stall_count=0, mem_timeout=0. All enables and flushes are forced to 0.
- Reset assertion mid-operation aborts immediately; there is no memory handshake clean-up.
- Hazard terms:
  - lu = load_EX & (R3_addr_EX!=0) & ((uses_R1_ID & R1_addr_ID==R3_addr_EX) | (uses_R2_ID & R2_addr_ID==R3_addr_EX))
  - mw = mem_req_MM & ~mem_ready
- RUN, in priority order:
  1. mw: all five enables=0, flushes=0, next=MEM_WAIT, timer<=1.
  2. branch_taken_EX: all enables=1, flush_IF=1, flush_ID=1; lu is ignored because the younger instruction is squashed.
  3. lu: pc_en=0, IF_en=0, ID_en=1, EX_en=1, MM_en=1, flush_ID=1. This inserts one bubble; the dependent instruction re-evaluates next cycle with the load in MM, so there is no stall state.
  4. Otherwise: all enables=1, flushes=0.
- MEM_WAIT:
  - mem_ready=1: apply RUN rules 2-4 in the same cycle (release cycle), next=RUN, timer<=0.
  - Else if timer==MEM_TIMEOUT: all enables=0, next=ERROR, mem_timeout<=1.
  - Else: all enables=0, flushes=0, timer<=timer+1.
  - A branch in EX while waiting is held because EX_en=0, and is acted on in the release cycle.
- ERROR: all enables=0, flushes=0, mem_timeout=1. The block leaves ERROR only through reset.
- stall_count increments on each clock where pc_en=0 and state!=ERROR, and saturates at all-ones.
- Register x0 is never a hazard source.

Decomposition:
- Shared package: state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2) and register-address width 5.
- One natural sub-module: hazard_detect, a combinational lu computation, reusable for forwarding-unit checks.

Test Plan:
- Load-use: load_EX=1, R3_addr_EX=5, uses_R1_ID=1, R1_addr_ID=5 -> same cycle pc_en=0, IF_en=0, flush_ID=1; the next cycle, with load_EX=0, gives all enables=1; stall_count=1.
- x0 guard: load_EX=1, R3_addr_EX=0, R1_addr_ID=0, uses_R1_ID=1 -> no stall, all enables=1.
- Branch beats load-use: branch_taken_EX=1 with the lu condition true -> all enables=1, flush_IF=1, flush_ID=1, stall_count unchanged.
- Memory wait: mem_req_MM=1, mem_ready=0 for 3 cycles then 1 -> enables=0 for 3 cycles, all 1 in the 4th; state returns to RUN; stall_count=3.
- Timeout: mem_req_MM=1, mem_ready=0 held for 20 cycles, MEM_TIMEOUT=15 -> ERROR entered after the 16th stalled cycle; mem_timeout=1 and stays set; enables stay 0; stall_count frozen at 16.
- Async reset: drive reset=0 mid-MEM_WAIT between clock edges -> outputs go 0 immediately, stall_count=0, mem_timeout=0; after release, state is RUN.
